// File: rtl/writeback_stage.sv
// writeback_stage
//
// Final pipeline stage. Merges ALU results and memory (load) results onto the
// register file's single write port. Load results are always queued in a small
// FIFO; ALU results win arbitration unless the FIFO has been passed over
// STARVE_LIMIT times in a row, in which case the FIFO head is forced out.
// The selected result is registered, giving a fixed one-cycle accept-to-write
// latency. Writes to x0 are consumed but never reach the register file.
//
// Optional feature: define WB_FORWARD_EN to expose the selected result
// combinationally on fwd_*_o so decode can bypass one cycle early. Without
// the macro fwd_*_o are tied to zero.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   alu_*           ALU result handshake (valid/ready, rd, data)
//   mem_*           load result handshake into the FIFO (valid/ready, rd, data)
//   write_*_o       registered register-file write port
//   wb_count_o      committed non-x0 writes, wraps at 2^32
//   fifo_level_o    current FIFO occupancy
//   fwd_*_o         same-cycle forwarding of the selected result

module writeback_stage #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  // ALU result path
  input  logic                          alu_valid_i,
  output logic                          alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0]         alu_data_i,
  // Memory result path
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic [ADDR_WIDTH-1:0]         mem_rd_i,
  input  logic [DATA_WIDTH-1:0]         mem_data_i,
  // Register file write port
  output logic                          write_enable_o,
  output logic [ADDR_WIDTH-1:0]         write_addr_o,
  output logic [DATA_WIDTH-1:0]         write_data_o,
  // Status
  output logic [31:0]                   wb_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  // Forwarding
  output logic                          fwd_valid_o,
  output logic [ADDR_WIDTH-1:0]         fwd_addr_o,
  output logic [DATA_WIDTH-1:0]         fwd_data_o
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned EntW   = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [LevelW-1:0] LevelFull = LevelW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]   CntLimit  = CntW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [EntW-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]     level_q, level_d;
  logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           wb_count_q, wb_count_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                  fifo_empty;
  logic                  starve;
  logic                  alu_sel;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  sel_commit;

  assign fifo_empty = (level_q == '0);
  assign starve     = !fifo_empty && (starve_cnt_q == CntLimit);

  assign alu_ready_o = !starve;
  // Readiness comes from registered occupancy only: a full FIFO refuses a
  // push even if it pops in the same cycle.
  assign mem_ready_o = (level_q != LevelFull);

  assign alu_sel   = alu_valid_i && alu_ready_o;
  assign fifo_pop  = !alu_sel && !fifo_empty;
  assign fifo_push = mem_valid_i && mem_ready_o;

  assign {head_rd, head_data} = fifo_mem_q[rd_ptr_q];

  always_comb begin
    sel_valid = alu_sel || fifo_pop;
    sel_rd    = head_rd;
    sel_data  = head_data;
    if (alu_sel) begin
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
    end
  end

  // x0 results are consumed but dropped.
  assign sel_commit = sel_valid && (sel_rd != '0);

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop cancel out.
    level_d = level_q + LevelW'(fifo_push) - LevelW'(fifo_pop);
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts ALU wins while loads are waiting.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (alu_sel && (starve_cnt_q != CntLimit)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    we_d       = sel_commit;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wb_count_d = wb_count_q;
    // Address/data only move on a real write; idle and x0 cycles hold them.
    if (sel_commit) begin
      waddr_d    = sel_rd;
      wdata_d    = sel_data;
      // Counted at the edge that raises write_enable so the count already
      // includes the write being presented.
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wb_count_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wb_count_q   <= wb_count_d;
    end
  end

  // Storage needs no reset: entries are only visible through level_q.
  always_ff @(posedge clk) begin
    if (!reset && fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= {mem_rd_i, mem_data_i};
    end
  end

  assign write_enable_o = we_q;
  assign write_addr_o   = waddr_q;
  assign write_data_o   = wdata_q;
  assign wb_count_o     = wb_count_q;
  assign fifo_level_o   = level_q;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
`ifdef WB_FORWARD_EN
  assign fwd_valid_o = sel_commit;
  assign fwd_addr_o  = sel_rd;
  assign fwd_data_o  = sel_data;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [31:0]   wb_count;
  logic [$clog2(DEPTH):0] fifo_level;
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  writeback_stage #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .mem_valid_i   (mem_valid),
    .mem_ready_o   (mem_ready),
    .mem_rd_i      (mem_rd),
    .mem_data_i    (mem_data),
    .write_enable_o(write_enable),
    .write_addr_o  (write_addr),
    .write_data_o  (write_data),
    .wb_count_o    (wb_count),
    .fifo_level_o  (fifo_level),
    .fwd_valid_o   (fwd_valid),
    .fwd_addr_o    (fwd_addr),
    .fwd_data_o    (fwd_data)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending loads plus the expected register-file view.
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  int            m_starve;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [31:0]   exp_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("write_enable", write_enable, exp_we);
    chk("write_addr", write_addr, exp_addr);
    chk("write_data", write_data, exp_data);
    chk("wb_count", wb_count, exp_cnt);
    chk("fifo_level", fifo_level, m_q.size());
  endtask

  task automatic model_clear();
    m_q.delete();
    m_starve = 0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_cnt  = '0;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registers.
  task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    int   sz;
    bit   st, a_sel, p_sel, push, any;
    ent_t head, e;
    logic [AW-1:0] s_rd;
    logic [DW-1:0] s_data;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    sz    = m_q.size();
    st    = (sz > 0) && (m_starve == LIMIT);
    a_sel = av && !st;
    p_sel = !a_sel && (sz > 0);
    push  = mv && (sz != DEPTH);
    any   = a_sel || p_sel;
    s_rd  = '0;
    s_data = '0;
    if (a_sel) begin
      s_rd = ard; s_data = ad;
    end else if (p_sel) begin
      head = m_q[0];
      s_rd = head.rd; s_data = head.data;
    end
    chk("alu_ready", alu_ready, !st);
    chk("mem_ready", mem_ready, sz != DEPTH);
`ifdef WB_FORWARD_EN
    chk("fwd_valid", fwd_valid, any && (s_rd != 0));
    if (any && (s_rd != 0)) begin
      chk("fwd_addr", fwd_addr, s_rd);
      chk("fwd_data", fwd_data, s_data);
    end
`else
    chk("fwd_valid", fwd_valid, 0);
    chk("fwd_addr", fwd_addr, 0);
    chk("fwd_data", fwd_data, 0);
`endif
    // Model update for the coming edge.
    if (p_sel) void'(m_q.pop_front());
    if (push) begin
      e.rd = mrd; e.data = md;
      m_q.push_back(e);
    end
    if (sz == 0 || p_sel) m_starve = 0;
    else if (a_sel && m_starve < LIMIT) m_starve++;
    exp_we = any && (s_rd != 0);
    if (exp_we) begin
      exp_addr = s_rd;
      exp_data = s_data;
      exp_cnt  = exp_cnt + 1;
    end
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset(input bit av, input bit mv);
    reset     = 1'b1;
    alu_valid = av; alu_rd = 5'd3; alu_data = 64'hDEAD;
    mem_valid = mv; mem_rd = 5'd4; mem_data = 64'hBEEF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    model_clear();
    chk_regs();
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && m_q.size() > 0; i++) idle();
    chk("drained_level", fifo_level, 0);
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    chk_regs();
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_mem_ready", mem_ready, 1);
    chk("reset_fwd_valid", fwd_valid, 0);

    // ALU only.
    cycle(1, 5'd5, 64'h1234, 0, '0, '0);
    chk("alu_we", write_enable, 1);
    chk("alu_addr", write_addr, 5);
    chk("alu_data", write_data, 64'h1234);
    chk("alu_count", wb_count, 1);

    // x0 drop.
    cycle(1, 5'd0, 64'hFF, 0, '0, '0);
    chk("x0_we", write_enable, 0);
    chk("x0_count", wb_count, 1);

    // FIFO fill under continuous ALU traffic, then forced starvation pop.
    cycle(1, 5'd10, 64'h100, 1, 5'd7, 64'hAA);
    for (int i = 1; i < DEPTH; i++)
      cycle(1, AW'(10 + i), DW'(64'h100 + i), 1, AW'(20 + i), DW'(64'h200 + i));
    chk("full_level", fifo_level, DEPTH);
    chk("full_mem_ready", mem_ready, 0);
    for (int i = DEPTH; i < LIMIT + 2; i++)
      cycle(1, AW'(10 + i), DW'(64'h100 + i), 0, '0, '0);
    chk("starve_addr", write_addr, 7);
    chk("starve_data", write_data, 64'hAA);
    chk("starve_level", fifo_level, DEPTH - 1);
    drain();

    // In-order drain of loads with no ALU traffic.
    cycle(0, '0, '0, 1, 5'd1, 64'h11);
    cycle(0, '0, '0, 1, 5'd2, 64'h22);
    chk("order_first", write_addr, 1);
    cycle(0, '0, '0, 1, 5'd3, 64'h33);
    chk("order_second", write_addr, 2);
    idle();
    chk("order_third", write_addr, 3);
    drain();

    // Forwarding of an ALU result.
    cycle(1, 5'd9, 64'h55, 0, '0, '0);

    // Reset mid-flight: three queued loads plus an accepted ALU result.
    for (int i = 0; i < 3; i++)
      cycle(1, AW'(12 + i), DW'(64'h300 + i), 1, AW'(24 + i), DW'(64'h400 + i));
    cycle(1, 5'd4, 64'h44, 0, '0, '0);
    do_reset(1, 1);
    chk("midrst_we", write_enable, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_count", wb_count, 0);
    repeat (3) idle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), {$urandom, $urandom},
              $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), {$urandom, $urandom});
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: collects results from the ALU path and the load/memory path and drives the register file's single write port (write_enable, write_addr, write_data). Memory results are buffered in a small FIFO. ALU results normally have priority, and a starvation counter guarantees the FIFO drains. A registered output stage gives a fixed one-cycle accept-to-write latency.

## Interface
- DATA_WIDTH, 64, result/register width
- ADDR_WIDTH, 5, register index width
- FIFO_DEPTH, 4, memory-result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive ALU wins allowed while FIFO non-empty (≥1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result present
- alu_ready  out  1  stage accepts ALU result this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  memory result present
- mem_ready  out  1  FIFO can accept (not full)
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- write_enable  out  1  register file write strobe (registered)
- write_addr  out  ADDR_WIDTH  register file write index (registered)
- write_data  out  DATA_WIDTH  register file write data (registered)
- wb_count  out  32  count of committed non-x0 writes
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- fwd_valid  out  1  forwarding valid (see Configuration)
- fwd_addr  out  ADDR_WIDTH  forwarding index
- fwd_data  out  DATA_WIDTH  forwarding data

## Operation
- Handshake: a transfer occurs when valid && ready are both high at a clk edge. Neither valid may depend on ready.
- mem_ready = (fifo_level != FIFO_DEPTH). It is computed from registered occupancy, so a full FIFO refuses a push even when it pops in the same cycle.
- Memory results always enter the FIFO; they never bypass it.
- Per-cycle selection, exactly one or none:
  - starve = FIFO non-empty && starve_cnt == STARVE_LIMIT.
  - alu_ready = !starve.
  - ALU is selected if alu_valid && alu_ready.
  - Otherwise the FIFO head is popped if the FIFO is non-empty.
- starve_cnt:
  - increments when the ALU is selected while the FIFO is non-empty;
  - clears to 0 on a FIFO pop or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- The selected result loads the output register.
  - write_enable = 1 only if rd != 0. A result with rd = 0 is consumed and dropped: write_enable stays 0 and wb_count does not change.
  - If nothing is selected, the next cycle has write_enable = 0, and write_addr/write_data hold their previous values.
- wb_count increments by 1 on each cycle that write_enable is 1 and wraps modulo 2^32.
- FIFO pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves fifo_level unchanged.

## Timing
- Reset values:
  - write_enable = 0, write_addr = 0, write_data = 0
  - wb_count = 0, fifo_level = 0, starve_cnt = 0
  - fwd_* = 0
  - alu_ready = 1, mem_ready = 1 (combinational, after reset)
- ALU path: accepted at edge N → write_enable high during cycle N+1 (1-cycle latency).
- Memory path with an empty FIFO and no ALU traffic: accepted at edge N → popped at edge N+1 → written during cycle N+2.
- Reset asserted mid-operation: FIFO contents and any pending output write are discarded, and write_enable is 0 in the cycle after the reset edge. No partial writes.
- At most one register file write per cycle.

## Configuration
- WB_FORWARD_EN defined:
  - fwd_valid, fwd_addr and fwd_data are combinational copies of the result selected this cycle.
  - fwd_valid = selected && rd != 0.
  - Decode can bypass one cycle before the register file write lands.
- Not defined: fwd_valid, fwd_addr and fwd_data are tied to 0, and no selection logic feeds them.

## Test plan
- ALU only: alu_valid=1, rd=5, data=0x1234 at edge N → write_enable=1, write_addr=5, write_data=0x1234 in cycle N+1; wb_count=1.
- x0 drop: alu rd=0, data=0xFF → alu_ready=1, write_enable stays 0, wb_count unchanged.
- FIFO fill: push FIFO_DEPTH=4 loads while alu_valid is held high → mem_ready=0 at fifo_level=4. Continue ALU traffic → after 8 consecutive ALU wins alu_ready=0 for one cycle, the head load (rd=7, 0xAA) is written, starve_cnt returns to 0, and fifo_level=3.
- Order: push loads rd=1,2,3 with no ALU traffic → writes appear in order 1,2,3 on consecutive cycles starting two cycles after the first push.
- Reset mid-flight: FIFO level 3 plus an ALU result accepted at edge N, reset high at edge N+1 → write_enable=0, fifo_level=0, wb_count=0 afterwards, and no write of the discarded entries.
- With WB_FORWARD_EN: ALU rd=9, data=0x55 accepted in cycle N → fwd_valid=1, fwd_addr=9, fwd_data=0x55 in the same cycle N. Without the macro, fwd_* remain 0.
